// File: rtl/filter_pad_inserter.sv
// Inserts boundaryWidth zero rows/columns around each RGB frame ahead of the kernel filter.
// Latency: 1 cycle from accepted input pixel (or pad decision) to registered oValid.
// Backpressure: holds output while iReady is low; stalls upstream (oReady=0) while pads are emitted.
//
// Ports:
//   clk, reset     - clock, asynchronous active-low reset
//   iValid/iData   - upstream pixel stream {R,G,B}; oReady accepts it
//   oValid/oData   - padded output stream, accepted by iReady; oPad flags pad pixels
//   oDone          - one-cycle pulse once the last padded pixel of a frame is accepted
module filter_pad_inserter #(
    parameter int width      = 320,
    parameter int height     = 240,
    parameter int kernelSize = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iValid,
    input  logic [23:0] iData,
    output logic        oReady,
    output logic        oValid,
    output logic [23:0] oData,
    input  logic        iReady,
    output logic        oPad,
    output logic        oDone
);

    localparam int BW   = (kernelSize - 1) / 2;
    localparam int PADW = width + 2 * BW;
    localparam int PADH = height + 2 * BW;
    localparam int XW   = $clog2(PADW + 1);
    localparam int YW   = $clog2(PADH + 1);

    localparam logic [XW-1:0] X_LAST = XW'(PADW - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(PADH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XW-1:0]   x_cnt;
    logic [YW-1:0]   y_cnt;

    logic is_pad;
    logic ld_ok;
    logic load;
    logic last_pos;

    // Integer compares keep the BW=0 case free of always-false unsigned tests.
    assign is_pad = (int'(x_cnt) < BW) || (int'(x_cnt) >= width + BW) ||
                    (int'(y_cnt) < BW) || (int'(y_cnt) >= height + BW);

    // Output register is free to take a new pixel when empty or being drained.
    assign ld_ok    = (state == RUN) && (!oValid || iReady);
    assign oReady   = ld_ok && !is_pad;
    assign load     = ld_ok && (is_pad || iValid);
    assign last_pos = (x_cnt == X_LAST) && (y_cnt == Y_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (iValid) state_nxt = RUN;
            RUN:     if (load && last_pos) state_nxt = FLUSH;
            FLUSH:   if (oValid && iReady) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            oValid <= 1'b0;
            oData  <= 24'd0;
            oPad   <= 1'b0;
            oDone  <= 1'b0;
            x_cnt  <= '0;
            y_cnt  <= '0;
        end else begin
            oDone <= 1'b0;
            case (state)
                RUN: begin
                    if (load) begin
                        oValid <= 1'b1;
                        oData  <= is_pad ? 24'd0 : iData;
                        oPad   <= is_pad;
                        if (x_cnt == X_LAST) begin
                            x_cnt <= '0;
                            y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + YW'(1);
                        end else begin
                            x_cnt <= x_cnt + XW'(1);
                        end
                    end else if (iReady) begin
                        // Data slot with no upstream pixel: the held one has drained.
                        oValid <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (oValid && iReady) begin
                        oValid <= 1'b0;
                        oDone  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_filter_pad_inserter.sv
module tb_filter_pad_inserter;

    logic        clk;
    logic        rst_n;
    logic        iv   [2];
    logic [23:0] idat [2];
    logic        ordy [2];
    logic        ov   [2];
    logic [23:0] odat [2];
    logic        ir   [2];
    logic        op   [2];
    logic        od   [2];

    int n_chk;
    int n_err;

    // Expected output entries: {pad, data}
    logic [24:0] exp_q[$];

    filter_pad_inserter #(.width(4), .height(2), .kernelSize(3)) dut_k3 (
        .clk(clk), .reset(rst_n),
        .iValid(iv[0]), .iData(idat[0]), .oReady(ordy[0]),
        .oValid(ov[0]), .oData(odat[0]), .iReady(ir[0]),
        .oPad(op[0]), .oDone(od[0])
    );

    filter_pad_inserter #(.width(4), .height(2), .kernelSize(1)) dut_k1 (
        .clk(clk), .reset(rst_n),
        .iValid(iv[1]), .iData(idat[1]), .oReady(ordy[1]),
        .oValid(ov[1]), .oData(odat[1]), .iReady(ir[1]),
        .oPad(op[1]), .oDone(od[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pixel n of the source stream, distinct in every byte lane.
    function automatic logic [23:0] pv(input int n);
        logic [7:0] b;
        b = 8'(n);
        return {b, 8'hA0 + b, 8'h0F ^ b};
    endfunction

    task automatic check_reset(input int sel);
        check_val("rst_ovalid", ov[sel], 0);
        check_val("rst_odata", odat[sel], 0);
        check_val("rst_opad", op[sel], 0);
        check_val("rst_odone", od[sel], 0);
        check_val("rst_oready", ordy[sel], 0);
    endtask

    // Drive nfr frames into instance sel; bubble = iValid-low cycles after each accepted pixel;
    // toggle = iReady alternates every cycle; stop_after > 0 ends early after that many outputs.
    task automatic run(input int sel, input int nfr, input int bubble, input int toggle,
                       input int stop_after);
        int w, h, bw, pw, ph, n_in, n_out, fed, outs, dones, gap, cyc, pix;
        bit exp_done, in_x, out_x, pad;
        w = 4; h = 2;
        bw = (sel == 0) ? 1 : 0;
        pw = w + 2 * bw;
        ph = h + 2 * bw;
        n_in  = w * h * nfr;
        n_out = pw * ph * nfr;
        fed = 0; outs = 0; dones = 0; gap = 0; cyc = 0; pix = 1;
        exp_done = 0;

        for (int f = 0; f < nfr; f++)
            for (int y = 0; y < ph; y++)
                for (int x = 0; x < pw; x++) begin
                    pad = (x < bw) || (x >= w + bw) || (y < bw) || (y >= h + bw);
                    if (pad) exp_q.push_back({1'b1, 24'd0});
                    else begin
                        exp_q.push_back({1'b0, pv(pix)});
                        pix++;
                    end
                end

        iv[sel]   = 1'b1;
        idat[sel] = pv(1);
        ir[sel]   = 1'b1;

        forever begin
            @(negedge clk);
            in_x  = iv[sel] && ordy[sel];
            out_x = ov[sel] && ir[sel];
            check_val("odone", od[sel], exp_done);
            exp_done = 0;
            if (od[sel]) dones++;
            if (ov[sel]) begin
                if (exp_q.size() == 0) check_val("extra_output", 1, 0);
                else begin
                    check_val("odata", odat[sel], exp_q[0][23:0]);
                    check_val("opad", op[sel], exp_q[0][24]);
                end
            end
            if (out_x && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                outs++;
                if (outs % (pw * ph) == 0) exp_done = 1;
            end
            if (in_x) fed++;
            if (stop_after > 0 && outs == stop_after) break;
            if (outs == n_out && !exp_done) break;
            cyc++;
            if (cyc > 2000) begin
                check_val("timeout_outs", outs, n_out);
                break;
            end
            @(posedge clk);
            #1;
            if (in_x) gap = bubble;
            if (fed >= n_in) iv[sel] = 1'b0;
            else if (gap > 0) begin
                iv[sel] = 1'b0;
                gap--;
            end else begin
                iv[sel]   = 1'b1;
                idat[sel] = pv(fed + 1);
            end
            ir[sel] = (toggle != 0) ? ~ir[sel] : 1'b1;
        end

        if (stop_after == 0) begin
            check_val("in_xfers", fed, n_in);
            check_val("out_xfers", outs, n_out);
            check_val("done_count", dones, nfr);
        end
        iv[sel] = 1'b0;
        ir[sel] = 1'b1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            iv[i]   = 1'b0;
            idat[i] = 24'd0;
            ir[i]   = 1'b1;
        end
        #1;
        check_reset(0);
        check_reset(1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run(0, 1, 0, 0, 0);   // no stall
        run(0, 1, 0, 1, 0);   // iReady toggling
        run(0, 1, 3, 0, 0);   // upstream bubbles
        run(0, 2, 0, 0, 0);   // back-to-back frames

        // Reset mid-frame after 10 output transfers
        run(0, 1, 0, 0, 10);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset(0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(0, 1, 0, 0, 0);   // fresh frame starts at a pad pixel

        run(1, 1, 0, 0, 0);   // kernelSize=1 pass-through
        run(1, 1, 3, 1, 0);   // pass-through with stalls on both sides

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/filter_pad_inserter.md
Name: filter_pad_inserter

Overview:
- Sits between the demosaic stage and the 7x7 filter.
- Takes the demosaiced RGB raster stream (width x height pixels) and produces the padded frame that the kernel filter consumes: boundaryWidth zero rows above and below, and boundaryWidth zero columns left and right of every row.
- Zero pad pixels are generated locally; upstream is stalled while pad pixels are emitted.
- Both sides use valid/ready handshakes, and the output is registered.

Parameters:
- width, 320, active pixels per input row
- height, 240, active rows per input frame
- kernelSize, 7, filter kernel size; odd, >= 1
- (local) boundaryWidth = (kernelSize-1)/2
- (local) padW = width + 2*boundaryWidth
- (local) padH = height + 2*boundaryWidth

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-low reset
- iValid  input  1  upstream pixel valid
- iData  input  24  upstream pixel {R[23:16], G[15:8], B[7:0]}
- oReady  output  1  upstream accept; a transfer occurs when iValid & oReady
- oValid  output  1  output pixel valid (registered)
- oData  output  24  output pixel, zero for pad positions
- iReady  input  1  downstream accept; a transfer occurs when oValid & iReady
- oPad  output  1  registered; high when the current oData is a pad pixel
- oDone  output  1  one-cycle pulse after the last padded pixel of a frame is accepted

Behaviour:
- Clocking and reset: single clock domain; reset is asynchronous and active-low.
- Reset values: oValid=0, oData=0, oPad=0, oDone=0, state=IDLE, xCnt=0, yCnt=0. oReady is combinational and is 0 during reset.
- Reset mid-frame: all of the above are cleared immediately. The partial frame is dropped and no oDone pulse is issued.
- Position counters:
  - xCnt counts 0..padW-1; yCnt counts 0..padH-1.
  - Both advance only on a load. On xCnt=padW-1, xCnt wraps to 0 and yCnt increments.
- Pad position: xCnt<boundaryWidth, or xCnt>=width+boundaryWidth, or yCnt<boundaryWidth, or yCnt>=height+boundaryWidth. Every other position is a data position.
- Load enable: ld_ok = (state==RUN) & (!oValid | iReady).
- Loading at a pad position:
  - Occurs when ld_ok.
  - oData<=0, oPad<=1, oValid<=1; counters advance.
  - oReady=0.
- Loading at a data position:
  - oReady = ld_ok (combinational; depends on iReady).
  - If iValid: oData<=iData, oPad<=0, oValid<=1; counters advance.
  - If !iValid: no load. If iReady is high, oValid falls to 0. Counters hold.
- Output hold: if oValid & !iReady, oData, oPad and the counters hold.
- Latency: 1 cycle from an accepted input (or a pad decision) to oValid.
- State machine:
  - IDLE: oReady=0, counters at 0. Goes to RUN on iValid=1. The triggering pixel is not consumed in IDLE.
  - RUN: loads as above. Loading the final position (xCnt=padW-1, yCnt=padH-1) clears the counters and goes to FLUSH.
  - FLUSH: oReady=0, no loads. When oValid & iReady, oValid<=0, oDone<=1 for one cycle, then IDLE.
- Frame totals: exactly padW*padH output transfers and exactly width*height input transfers per frame.
- Input during FLUSH/IDLE: not consumed. The upstream holds the pixel, and it becomes the first pixel of the next frame.
- kernelSize=1: boundaryWidth=0, so the block is a pure registered pass-through with frame counting and oDone.
- Simultaneous events:
  - Output transfer and new load in the same cycle are allowed (full throughput: 1 pixel/cycle with iReady held high).
  - oDone and an iValid in the same cycle: the next frame starts from IDLE on the following cycle.

Test Plan:
- Small config, no stall (width=4, height=2, kernelSize=3, iReady=1, iValid=1, iData=1..8):
  - -> 24 output transfers; oPad pattern is row 0 all 1; rows 1-2 = 1,0,0,0,0,1; row 3 all 1.
  - -> oData on data slots is 1..8 in order; oDone pulses once, 1 cycle after the 24th transfer.
- Same config, iReady toggling 1,0,1,0:
  - -> oData/oPad held stable while iReady=0; output sequence identical to the no-stall case; no input lost or duplicated (oReady asserts exactly 8 times with iValid).
- Upstream bubbles (iValid low 3 cycles at every data position):
  - -> pad pixels still issue without waiting; data slots wait; sequence unchanged; 8 input transfers.
- Back-to-back frames (iValid held high, 16 pixels supplied):
  - -> 2 oDone pulses; second frame data 9..16; 48 output transfers total.
- Reset low mid-frame (after 10 output transfers), then high:
  - -> oValid=0, oData=0, oDone=0 immediately; next frame starts at a pad pixel with xCnt=yCnt=0.
- kernelSize=1, width=4, height=2:
  - -> 8 output transfers, oPad always 0, oData equals input, oDone after 8th transfer.
